laser_frame_feeder: RTL and testbench
=====================================

// Module: laser_frame_feeder
// PURPOSE
//  Upstream stage of the LASER circle-placement engine. Accepts point frames of
//  N_OBJ (X,Y) pairs over a valid/ready stream and double-buffers them. Resets
//  LASER, then replays a frame on its X/Y inputs in N_OBJ consecutive cycles.
//  Captures C1X/C1Y/C2X/C2Y on DONE and returns them on a valid/ready result port.
// PARAMETERS
//  N_OBJ    40     points per frame; the LASER read length
//  COORD_W  4      bits per coordinate
//  TMO      65535  max cycles in S_WAIT before a timeout result is issued
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        synchronous, active-high reset
//  IN_VALID   in   1        input point valid
//  IN_READY   out  1        feeder can accept a point (write bank not full)
//  IN_X       in   COORD_W  point X
//  IN_Y       in   COORD_W  point Y
//  L_RST      out  1        reset to LASER; high during RST and in S_KICK
//  L_X        out  COORD_W  point X driven to LASER
//  L_Y        out  COORD_W  point Y driven to LASER
//  L_DONE     in   1        LASER DONE; single-cycle pulse
//  L_C1X,L_C1Y,L_C2X,L_C2Y  in  COORD_W each  LASER results, valid with L_DONE
//  RES_VALID  out  1        result available
//  RES_READY  in   1        result consumer ready
//  RES_C1X,RES_C1Y,RES_C2X,RES_C2Y  out  COORD_W each  captured centres
//  RES_TMO    out  1        result came from a timeout; all coordinates are 0
// BEHAVIOUR
//  Reset values:
//   - IN_READY=0 while RST, else 1; RES_* outputs=0; L_X=L_Y=0; L_RST=1.
//   - Both banks empty; wr_bank=rd_bank=0; FSM in S_IDLE.
//  Input side:
//   - A point is accepted on IN_VALID&IN_READY and written to bank[wr_bank][wr_idx].
//   - wr_idx counts 0..N_OBJ-1. On write of index N_OBJ-1: mark bank full, clear wr_idx, toggle wr_bank.
//   - IN_READY = !full[wr_bank].
//  FSM (one-hot or binary, registered):
//   - S_IDLE: go to S_KICK when full[rd_bank] && !RES_VALID.
//   - S_KICK: exactly 1 cycle. L_RST=1. rd_idx=0.
//   - S_STREAM: N_OBJ cycles. Drive bank[rd_bank][rd_idx] on L_X/L_Y from a register.
//     Point 0 appears in the first cycle after L_RST falls; rd_idx increments each cycle.
//     After index N_OBJ-1 go to S_WAIT and clear tmo_cnt.
//   - S_WAIT: L_X/L_Y=0; tmo_cnt increments.
//     On L_DONE: latch L_C*, RES_VALID<=1, RES_TMO<=0, clear full[rd_bank], toggle rd_bank, go to S_IDLE.
//     On tmo_cnt==TMO without L_DONE: same actions, but coordinates 0 and RES_TMO<=1.
//   - L_DONE outside S_WAIT is ignored.
//  Result port:
//   - RES_* stay stable while RES_VALID && !RES_READY.
//   - RES_VALID clears the cycle after the handshake.
//   - A new frame starts only after the pending result is taken, so no result is lost.
//  Boundaries:
//   - Simultaneous fill of wr_bank and bank release in the same cycle are both honoured.
//     Full flags are set and cleared per bank independently.
//   - Both banks full: IN_READY=0; input stalls with no data lost.
//   - Gaps in IN_VALID mid-frame: allowed; a partial frame is never streamed.
//   - RST mid-stream or mid-wait: partial input frame discarded, state returns to reset values.
//     LASER is held in reset via L_RST.
//  Latency: frame complete -> L_RST pulse <=2 cycles when idle.
//   L_DONE -> RES_VALID: 1 cycle.
// TESTING
//  1. Single frame (pts (i%16, i/4%16), i=0..39):
//     one L_RST pulse, then exactly 40 L_X/L_Y cycles in order.
//     Model L_DONE after 100 cycles with C1=(3,4), C2=(9,10) -> RES_VALID with (3,4,9,10), RES_TMO=0.
//  2. Back-to-back: 3 frames pushed without gaps.
//     IN_READY drops after frame 2 and reasserts when frame 1 is released.
//     Results return in order 1,2,3.
//  3. RES_READY held 0 for 500 cycles:
//     result stable; no S_KICK for the queued frame until the handshake.
//  4. Timeout with TMO=200 and no L_DONE:
//     RES_VALID at S_WAIT cycle 200, RES_TMO=1, coords 0; next frame proceeds.
//  5. RST asserted at stream index 17:
//     next cycle L_RST=1, RES_VALID=0, IN_READY=0.
//     After release a fresh frame streams from index 0.
//  6. Stray L_DONE during S_STREAM -> ignored; the later real L_DONE is captured.

Source files
------------

// File: rtl/laser_frame_feeder.sv
// laser_frame_feeder: double-buffers point frames, replays them into LASER and returns its centres
module laser_frame_feeder #(
    parameter int N_OBJ   = 40,
    parameter int COORD_W = 4,
    parameter int TMO     = 65535
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [COORD_W-1:0] IN_X,
    input  logic [COORD_W-1:0] IN_Y,
    output logic               L_RST,
    output logic [COORD_W-1:0] L_X,
    output logic [COORD_W-1:0] L_Y,
    input  logic               L_DONE,
    input  logic [COORD_W-1:0] L_C1X,
    input  logic [COORD_W-1:0] L_C1Y,
    input  logic [COORD_W-1:0] L_C2X,
    input  logic [COORD_W-1:0] L_C2Y,
    output logic               RES_VALID,
    input  logic               RES_READY,
    output logic [COORD_W-1:0] RES_C1X,
    output logic [COORD_W-1:0] RES_C1Y,
    output logic [COORD_W-1:0] RES_C2X,
    output logic [COORD_W-1:0] RES_C2Y,
    output logic               RES_TMO
);
    localparam int IW = $clog2(N_OBJ);
    localparam int TW = $clog2(TMO + 1);
    localparam logic [IW-1:0] LAST = IW'(N_OBJ - 1);
    localparam logic [TW-1:0] TMO_V = TW'(TMO);

    typedef enum logic [1:0] {S_IDLE, S_KICK, S_STREAM, S_WAIT} state_t;

    state_t                 state_q, state_d;
    logic [COORD_W-1:0]     mem_x_q [2][N_OBJ];
    logic [COORD_W-1:0]     mem_x_d [2][N_OBJ];
    logic [COORD_W-1:0]     mem_y_q [2][N_OBJ];
    logic [COORD_W-1:0]     mem_y_d [2][N_OBJ];
    logic [1:0]             full_q, full_d;
    logic                   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [IW-1:0]          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, rd_nxt;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic [COORD_W-1:0]     l_x_q, l_x_d, l_y_q, l_y_d;
    logic                   res_valid_q, res_valid_d, res_tmo_q, res_tmo_d;
    logic [4*COORD_W-1:0]   res_c_q, res_c_d;
    logic                   wr_en;

    assign IN_READY  = !RST && !full_q[wr_bank_q];
    assign wr_en     = IN_VALID && IN_READY;
    assign rd_nxt    = rd_idx_q + IW'(1);
    assign L_RST     = RST || state_q == S_KICK;
    assign L_X       = l_x_q;
    assign L_Y       = l_y_q;
    assign RES_VALID = res_valid_q;
    assign RES_TMO   = res_tmo_q;
    assign {RES_C1X, RES_C1Y, RES_C2X, RES_C2Y} = res_c_q;

    always_comb begin
        mem_x_d     = mem_x_q;
        mem_y_d     = mem_y_q;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        state_d     = state_q;
        rd_bank_d   = rd_bank_q;
        rd_idx_d    = rd_idx_q;
        tmo_cnt_d   = tmo_cnt_q;
        l_x_d       = '0;
        l_y_d       = '0;
        res_valid_d = res_valid_q && !RES_READY;
        res_tmo_d   = res_tmo_q;
        res_c_d     = res_c_q;
        if (wr_en) begin
            mem_x_d[wr_bank_q][wr_idx_q] = IN_X;
            mem_y_d[wr_bank_q][wr_idx_q] = IN_Y;
            wr_idx_d = wr_idx_q == LAST ? '0 : wr_idx_q + IW'(1);
            if (wr_idx_q == LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        case (state_q)
            S_IDLE: state_d = full_q[rd_bank_q] && !res_valid_q ? S_KICK : S_IDLE;
            S_KICK: begin
                state_d  = S_STREAM;
                rd_idx_d = '0;
                l_x_d    = mem_x_q[rd_bank_q][0];
                l_y_d    = mem_y_q[rd_bank_q][0];
            end
            S_STREAM: begin
                if (rd_idx_q == LAST) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                end else begin
                    rd_idx_d = rd_nxt;
                    l_x_d    = mem_x_q[rd_bank_q][rd_nxt];
                    l_y_d    = mem_y_q[rd_bank_q][rd_nxt];
                end
            end
            S_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
                if (L_DONE || tmo_cnt_q == TMO_V) begin
                    state_d           = S_IDLE;
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = !rd_bank_q;
                    res_valid_d       = 1'b1;
                    res_tmo_d         = !L_DONE;
                    res_c_d           = L_DONE ? {L_C1X, L_C1Y, L_C2X, L_C2Y} : '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            tmo_cnt_q   <= '0;
            l_x_q       <= '0;
            l_y_q       <= '0;
            res_valid_q <= 1'b0;
            res_tmo_q   <= 1'b0;
            res_c_q     <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            tmo_cnt_q   <= tmo_cnt_d;
            l_x_q       <= l_x_d;
            l_y_q       <= l_y_d;
            res_valid_q <= res_valid_d;
            res_tmo_q   <= res_tmo_d;
            res_c_q     <= res_c_d;
        end
    end

    always_ff @(posedge CLK) begin
        mem_x_q <= mem_x_d;
        mem_y_q <= mem_y_d;
    end
endmodule

// File: tb/tb_laser_frame_feeder.sv
// tb_laser_frame_feeder: directed stimulus with a frame-queue model checked every cycle
module tb_laser_frame_feeder;
    localparam int N    = 40;
    localparam int W    = 4;
    localparam int TMO  = 200;
    localparam int IDLE = -1;

    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, l_done = 1'b0, res_ready = 1'b0;
    logic [W-1:0] in_x = '0, in_y = '0, l_c1x = '0, l_c1y = '0, l_c2x = '0, l_c2y = '0;
    logic         in_ready, l_rst, res_valid, res_tmo;
    logic [W-1:0] l_x, l_y, res_c1x, res_c1y, res_c2x, res_c2y;

    int n_tests = 0, n_fail = 0;
    logic armed = 1'b0;

    logic [15:0] resp_q[$];
    logic        resp_en = 1'b1, stray = 1'b0;
    int          resp_at = 100;

    logic [N*8-1:0] fq[$];
    logic [N*8-1:0] cur = '0, head;
    int             cnt = 0, m_ph = IDLE, wc = 0;
    logic           m_rv = 1'b0, m_tmo = 1'b0, e_ready, rv0, rel, fill;
    logic [15:0]    m_res = '0;
    logic [7:0]     e_lxy;

    laser_frame_feeder #(.N_OBJ(N), .COORD_W(W), .TMO(TMO)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_X(in_x), .IN_Y(in_y), .L_RST(l_rst), .L_X(l_x), .L_Y(l_y),
        .L_DONE(l_done), .L_C1X(l_c1x), .L_C1Y(l_c1y), .L_C2X(l_c2x), .L_C2Y(l_c2y),
        .RES_VALID(res_valid), .RES_READY(res_ready),
        .RES_C1X(res_c1x), .RES_C1Y(res_c1y), .RES_C2X(res_c2x), .RES_C2Y(res_c2y),
        .RES_TMO(res_tmo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pt(input int f, input int i);
        return f == 0 ? {4'(i % 16), 4'((i / 4) % 16)} : {4'((i + 3 * f) % 16), 4'((7 * i + f) % 16)};
    endfunction

    // Model: completed frames queue up (at most two), the oldest is kicked, streamed, then waited on.
    always @(negedge clk) begin
        if (armed) begin
            e_ready = !rst && fq.size() < 2;
            head = fq.size() > 0 ? fq[0] : '0;
            e_lxy = (m_ph >= 1 && m_ph <= N) ? head[(m_ph-1)*8 +: 8] : 8'h00;
            chk("in_ready", 16'(in_ready), 16'(e_ready));
            chk("l_rst", 16'(l_rst), 16'(rst || m_ph == 0));
            chk("l_xy", 16'({l_x, l_y}), 16'(e_lxy));
            chk("res_valid", 16'(res_valid), 16'(m_rv));
            if (m_rv) begin
                chk("res_c", {res_c1x, res_c1y, res_c2x, res_c2y}, m_res);
                chk("res_tmo", 16'(res_tmo), 16'(m_tmo));
            end
            if (rst) begin
                fq.delete();
                cnt = 0; m_ph = IDLE; m_rv = 1'b0; m_tmo = 1'b0; m_res = '0;
            end else begin
                rv0 = m_rv; rel = 1'b0; fill = 1'b0;
                if (rv0 && res_ready) m_rv = 1'b0;
                if (m_ph == IDLE) begin
                    if (fq.size() > 0 && !rv0) m_ph = 0;
                end else if (m_ph <= N) begin
                    m_ph++;
                    wc = 0;
                end else if (l_done || wc == TMO) begin
                    m_rv  = 1'b1;
                    m_tmo = !l_done;
                    m_res = l_done ? {l_c1x, l_c1y, l_c2x, l_c2y} : 16'h0;
                    rel   = 1'b1;
                    m_ph  = IDLE;
                end else wc++;
                if (in_valid && e_ready) begin
                    cur[cnt*8 +: 8] = {in_x, in_y};
                    cnt++;
                    if (cnt == N) begin fill = 1'b1; cnt = 0; end
                end
                if (rel) void'(fq.pop_front());
                if (fill) fq.push_back(cur);
            end
        end
    end

    // LASER stand-in: after each kick answers resp_at cycles into the stream, optionally with a stray early DONE.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && l_rst) begin
                for (int k = 0; k <= resp_at; k++) begin
                    @(posedge clk); #2;
                    l_done = 1'b0;
                    if (rst) break;
                    if (k == resp_at && resp_en) begin
                        l_done = 1'b1;
                        {l_c1x, l_c1y, l_c2x, l_c2y} = resp_q.size() > 0 ? resp_q.pop_front() : 16'h0;
                    end else if (stray && k == 10) begin
                        l_done = 1'b1;
                        {l_c1x, l_c1y, l_c2x, l_c2y} = 16'hEEEE;
                    end
                end
                @(posedge clk); #2;
                l_done = 1'b0;
            end
        end
    end

    task automatic push_pts(input int f, input int n);
        for (int i = 0; i < n; i++) begin
            int b = 0;
            in_valid = 1'b1;
            {in_x, in_y} = pt(f, i);
            while (!in_ready && b < 5000) begin @(posedge clk); #1; b++; end
            if (b >= 5000) chk("push_ready", 16'(in_ready), 16'h1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_kick(input string nm, input int lim, output int c);
        c = 0;
        while (!(l_rst && !rst) && c < lim) begin @(posedge clk); #1; c++; end
        if (c >= lim) chk({nm, "_kick"}, 16'(l_rst), 16'h1);
    endtask

    task automatic wait_rv(input int lim, output int c);
        c = 0;
        while (!res_valid && c < lim) begin @(posedge clk); #1; c++; end
    endtask

    task automatic get_result(input string nm, input logic [15:0] e, input logic et);
        int c;
        wait_rv(2000, c);
        chk({nm, "_valid"}, 16'(res_valid), 16'h1);
        chk({nm, "_res"}, {res_c1x, res_c1y, res_c2x, res_c2y}, e);
        chk({nm, "_tmo"}, 16'(res_tmo), 16'(et));
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: run exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c2, kicks;
        repeat (3) @(posedge clk);
        #1;
        armed = 1'b1;
        chk("rst_in_ready", 16'(in_ready), 16'h0);
        chk("rst_l_rst", 16'(l_rst), 16'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("init_in_ready", 16'(in_ready), 16'h1);
        chk("init_l_rst", 16'(l_rst), 16'h0);
        chk("init_res", {res_c1x, res_c1y, res_c2x, res_c2y, 3'b0, res_valid}, 16'h0);
        chk("init_lxy", 16'({l_x, l_y, res_tmo}), 16'h0);

        resp_q.push_back(16'h349A);
        push_pts(0, N);
        wait_kick("t1", 10, c);
        chk("t1_kick_lat", 16'(c >= 1 && c <= 2), 16'h1);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        chk("t1_pt5", 16'({l_x, l_y}), 16'h0051);
        repeat (34) @(posedge clk);
        #1;
        chk("t1_pt39", 16'({l_x, l_y}), 16'h0079);
        @(posedge clk); #1;
        chk("t1_wait_xy", 16'({l_x, l_y}), 16'h0000);
        wait_rv(500, c2);
        chk("t1_done_lat", 16'(41 + c2), 16'd102);
        get_result("t1", 16'h349A, 1'b0);

        resp_q.push_back(16'h1234);
        resp_q.push_back(16'h5678);
        resp_q.push_back(16'h9ABC);
        push_pts(1, N);
        push_pts(2, N);
        chk("t2_ready_drop", 16'(in_ready), 16'h0);
        push_pts(3, N);
        get_result("t2a", 16'h1234, 1'b0);
        get_result("t2b", 16'h5678, 1'b0);
        get_result("t2c", 16'h9ABC, 1'b0);

        resp_q.push_back(16'hA1B2);
        resp_q.push_back(16'hC3D4);
        push_pts(4, N);
        push_pts(5, N);
        wait_rv(1000, c);
        kicks = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            kicks += int'(l_rst);
        end
        chk("t3_no_kick", 16'(kicks), 16'h0);
        chk("t3_held", {res_c1x, res_c1y, res_c2x, res_c2y}, 16'hA1B2);
        get_result("t3a", 16'hA1B2, 1'b0);
        wait_kick("t3", 10, c);
        chk("t3_kick_after", 16'(c >= 1 && c <= 2), 16'h1);
        get_result("t3b", 16'hC3D4, 1'b0);

        resp_en = 1'b0;
        push_pts(6, N);
        wait_kick("t4", 10, c);
        wait_rv(1000, c2);
        chk("t4_tmo_lat", 16'(c2), 16'd242);
        get_result("t4", 16'h0000, 1'b1);
        resp_en = 1'b1;
        resp_q.push_back(16'h7E57);
        push_pts(7, N);
        get_result("t4_next", 16'h7E57, 1'b0);

        push_pts(8, N);
        push_pts(9, 10);
        c = 0;
        while (m_ph != 18 && c < 500) begin @(posedge clk); #1; c++; end
        chk("t5_reach17", 16'({l_x, l_y}), 16'(pt(8, 17)));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t5_l_rst", 16'(l_rst), 16'h1);
        chk("t5_res_valid", 16'(res_valid), 16'h0);
        chk("t5_in_ready", 16'(in_ready), 16'h0);
        chk("t5_lxy", 16'({l_x, l_y}), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        resp_q.push_back(16'h2468);
        push_pts(10, N);
        wait_kick("t5", 10, c);
        @(posedge clk); #1;
        chk("t5_fresh_pt0", 16'({l_x, l_y}), 16'(pt(10, 0)));
        get_result("t5", 16'h2468, 1'b0);

        stray = 1'b1;
        resp_q.push_back(16'h3C5A);
        push_pts(11, N);
        get_result("t6", 16'h3C5A, 1'b0);
        stray = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
